// File: rtl/obi_ext_slice.sv
// Registered OBI slice: 2-entry request FIFO plus outstanding-transaction bound.
// Define OBI_EXT_SLICE_RSP_REG_EN to add one register stage on rvalid/rdata.
package obi_pkg;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

endpackage

module obi_ext_slice
    import obi_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  obi_req_t  slv_req_i,
    output obi_resp_t slv_resp_o,
    output obi_req_t  mst_req_o,
    input  obi_resp_t mst_resp_i
);

    localparam int unsigned IW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [IW-1:0] MAX_CNT = IW'(MAX_OUTSTANDING);

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } entry_t;

    entry_t [1:0]  mem;
    entry_t        head;
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    cnt;
    logic [IW-1:0] inflight;
    logic          full;
    logic          empty;
    logic          gnt;
    logic          push;
    logic          pop;
    logic          dec;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;

    assign full  = (cnt == 2'd2);
    assign empty = (cnt == 2'd0);

    // Grant depends on registered state only; no path from mst_resp_i.gnt.
    assign gnt  = !full && (inflight < MAX_CNT);
    assign push = slv_req_i.req && gnt;
    assign pop  = !empty && mst_resp_i.gnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem    <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{
                    we:    slv_req_i.we,
                    be:    slv_req_i.be,
                    addr:  slv_req_i.addr,
                    wdata: slv_req_i.wdata
                };
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({push, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign head = mem[rd_ptr];

    assign mst_req_o = '{
        req:   !empty,
        we:    head.we,
        be:    head.be,
        addr:  head.addr,
        wdata: head.wdata
    };

`ifdef OBI_EXT_SLICE_RSP_REG_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= mst_resp_i.rvalid;
            if (mst_resp_i.rvalid) begin
                rsp_rdata <= mst_resp_i.rdata;
            end
        end
    end
`else
    assign rsp_valid = mst_resp_i.rvalid;
    assign rsp_rdata = mst_resp_i.rdata;
`endif

    assign slv_resp_o = '{
        gnt:    gnt,
        rvalid: rsp_valid,
        rdata:  rsp_rdata
    };

    // Saturate at zero so a spurious response cannot wrap the counter.
    assign dec = rsp_valid && (inflight != '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inflight <= '0;
        end else begin
            unique case ({push, dec})
                2'b10:   inflight <= inflight + IW'(1);
                2'b01:   inflight <= inflight - IW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

`ifndef SYNTHESIS
    spurious_rvalid: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        rsp_valid |-> (inflight != '0)
    ) else $warning("obi_ext_slice: rvalid with nothing outstanding");
`endif

endmodule

// File: tb/tb_obi_ext_slice.sv
// Directed bench for obi_ext_slice with a small in-order scoreboard.
// Instance u_a uses MAX_OUTSTANDING=2, u_b uses MAX_OUTSTANDING=4.
module tb_obi_ext_slice;
    import obi_pkg::*;

`ifdef OBI_EXT_SLICE_RSP_REG_EN
    localparam int RSP_LAT = 1;
`else
    localparam int RSP_LAT = 0;
`endif
    localparam logic [31:0] K = 32'h5a5a_5a5a;

    logic      clk = 1'b0;
    logic      rst_n;
    obi_req_t  a_req, a_mreq, b_req, b_mreq;
    obi_resp_t a_rsp, a_mrsp, b_rsp, b_mrsp;
    int        checks = 0;
    int        failures = 0;

    always #5 clk = ~clk;

    obi_ext_slice #(.MAX_OUTSTANDING(2)) u_a (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .slv_req_i  (a_req),
        .slv_resp_o (a_rsp),
        .mst_req_o  (a_mreq),
        .mst_resp_i (a_mrsp)
    );

    obi_ext_slice #(.MAX_OUTSTANDING(4)) u_b (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .slv_req_i  (b_req),
        .slv_resp_o (b_rsp),
        .mst_req_o  (b_mreq),
        .mst_resp_i (b_mrsp)
    );

    task automatic check(input string tag,
                         input logic [95:0] got,
                         input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    function automatic obi_req_t mk(input logic we,
                                    input logic [31:0] addr,
                                    input logic [31:0] wdata);
        obi_req_t r;
        r.req   = 1'b1;
        r.we    = we;
        r.be    = 4'hf;
        r.addr  = addr;
        r.wdata = wdata;
        return r;
    endfunction

    function automatic obi_req_t rnd_txn(input int n);
        obi_req_t r;
        r.req   = 1'b1;
        r.we    = 1'($urandom_range(0, 1));
        r.be    = 4'($urandom_range(1, 15));
        r.addr  = 32'h5000_0000 | (32'(n) << 2);
        r.wdata = $urandom;
        return r;
    endfunction

    task automatic t_single();
        cyc();
        a_req = mk(1'b0, 32'h2000_0010, 32'h0);
        a_mrsp.gnt = 1'b1;
        mid();
        check("rd_gnt", 96'(a_rsp.gnt), 96'(1));
        check("rd_mreq_lat", 96'(a_mreq.req), 96'(0));
        cyc();
        a_req = '0;
        mid();
        check("rd_mreq", 96'(a_mreq.req), 96'(1));
        check("rd_addr", 96'(a_mreq.addr), 96'(32'h2000_0010));
        check("rd_we", 96'(a_mreq.we), 96'(0));
        cyc();
        a_mrsp.rvalid = 1'b1;
        a_mrsp.rdata  = 32'hdead_beef;
`ifdef OBI_EXT_SLICE_RSP_REG_EN
        mid();
        check("rd_rv_early", 96'(a_rsp.rvalid), 96'(0));
        cyc();
        a_mrsp.rvalid = 1'b0;
        a_mrsp.rdata  = 32'h0;
`endif
        mid();
        check("rd_rvalid", 96'(a_rsp.rvalid), 96'(1));
        check("rd_rdata", 96'(a_rsp.rdata), 96'(32'hdead_beef));
        cyc();
        a_mrsp.rvalid = 1'b0;
        a_mrsp.rdata  = 32'h0;
        mid();
        check("rd_rv_off", 96'(a_rsp.rvalid), 96'(0));
        check("rd_inflight", 96'(u_a.inflight), 96'(0));
    endtask

    task automatic t_backpressure();
        obi_req_t w[4];
        obi_req_t q[$];
        int idx = 0;
        int grants = 0;
        int unstable = 0;
        logic rv_next = 1'b0;
        for (int i = 0; i < 4; i++)
            w[i] = mk(1'b1, 32'h1000 + 32'(i * 4),
                      32'ha0a0_0000 + 32'(i));
        b_mrsp = '0;
        for (int c = 0; c < 5; c++) begin
            cyc();
            b_req = (idx < 4) ? w[idx] : '0;
            mid();
            if (b_rsp.gnt) begin
                grants++;
                idx++;
            end
            if (c >= 1 && b_mreq !== w[0]) unstable++;
        end
        check("bp_grants", 96'(grants), 96'(2));
        check("bp_gnt_low", 96'(b_rsp.gnt), 96'(0));
        check("bp_stable", 96'(unstable), 96'(0));
        for (int c = 0; c < 40 && !(idx == 4 && q.size() == 4); c++) begin
            cyc();
            b_req = (idx < 4) ? w[idx] : '0;
            b_mrsp.gnt    = 1'b1;
            b_mrsp.rvalid = rv_next;
            mid();
            if (b_req.req && b_rsp.gnt) idx++;
            rv_next = b_mreq.req;
            if (b_mreq.req) q.push_back(b_mreq);
        end
        cyc();
        b_req = '0;
        b_mrsp.gnt    = 1'b0;
        b_mrsp.rvalid = rv_next;
        cyc();
        b_mrsp.rvalid = 1'b0;
        cyc();
        mid();
        check("bp_count", 96'(q.size()), 96'(4));
        for (int i = 0; i < q.size() && i < 4; i++)
            check("bp_order", 96'(q[i]), 96'(w[i]));
        check("bp_empty", 96'(b_mreq.req), 96'(0));
        check("bp_inflight", 96'(u_b.inflight), 96'(0));
    endtask

    task automatic t_limit();
        obi_req_t r[4];
        int gc[4];
        int due[$];
        logic [31:0] dd[$];
        logic [31:0] got_rd[$];
        int idx = 0;
        int first_rv = -1;
        for (int i = 0; i < 4; i++) begin
            r[i]  = mk(1'b0, 32'h3000 + 32'(i * 4), 32'h0);
            gc[i] = -1;
        end
        a_mrsp.gnt = 1'b1;
        for (int c = 0; c < 40; c++) begin
            cyc();
            a_req = (idx < 4) ? r[idx] : '0;
            if (due.size() > 0 && due[0] == c) begin
                a_mrsp.rvalid = 1'b1;
                a_mrsp.rdata  = dd.pop_front();
                void'(due.pop_front());
            end else begin
                a_mrsp.rvalid = 1'b0;
                a_mrsp.rdata  = 32'h0;
            end
            mid();
            if (a_req.req && a_rsp.gnt) begin
                gc[idx] = c;
                idx++;
            end
            if (a_mreq.req) begin
                due.push_back(c + 10);
                dd.push_back(a_mreq.addr ^ K);
            end
            if (a_rsp.rvalid) begin
                if (first_rv < 0) first_rv = c;
                got_rd.push_back(a_rsp.rdata);
            end
        end
        a_req  = '0;
        a_mrsp = '0;
        check("lim_g0", 96'(gc[0]), 96'(0));
        check("lim_g1", 96'(gc[1]), 96'(1));
        check("lim_first_rv", 96'(first_rv), 96'(11 + RSP_LAT));
        check("lim_g2", 96'(gc[2]), 96'(12 + RSP_LAT));
        check("lim_g3", 96'(gc[3]), 96'(13 + RSP_LAT));
        check("lim_nrsp", 96'(got_rd.size()), 96'(4));
        for (int i = 0; i < got_rd.size() && i < 4; i++)
            check("lim_rdata", 96'(got_rd[i]), 96'(r[i].addr ^ K));
    endtask

    task automatic t_simul();
        obi_req_t t1, t2;
        t1 = mk(1'b0, 32'h4000_0000, 32'h0);
        t2 = mk(1'b1, 32'h4000_0004, 32'h1234_5678);
        b_mrsp = '0;
        cyc();
        b_req = t1;
        mid();
        check("sim_gnt1", 96'(b_rsp.gnt), 96'(1));
`ifdef OBI_EXT_SLICE_RSP_REG_EN
        cyc();
        b_req = '0;
        b_mrsp.rvalid = 1'b1;
        b_mrsp.rdata  = 32'hcafe_f00d;
        cyc();
        b_req = t2;
        b_mrsp.gnt    = 1'b1;
        b_mrsp.rvalid = 1'b0;
`else
        cyc();
        b_req = t2;
        b_mrsp.gnt    = 1'b1;
        b_mrsp.rvalid = 1'b1;
        b_mrsp.rdata  = 32'hcafe_f00d;
`endif
        mid();
        check("sim_pre_infl", 96'(u_b.inflight), 96'(1));
        check("sim_pre_cnt", 96'(u_b.cnt), 96'(1));
        check("sim_pre_head", 96'(b_mreq), 96'(t1));
        check("sim_rvalid", 96'(b_rsp.rvalid), 96'(1));
        check("sim_rdata", 96'(b_rsp.rdata), 96'(32'hcafe_f00d));
        check("sim_gnt2", 96'(b_rsp.gnt), 96'(1));
        cyc();
        b_req  = '0;
        b_mrsp = '0;
        mid();
        check("sim_infl", 96'(u_b.inflight), 96'(1));
        check("sim_cnt", 96'(u_b.cnt), 96'(1));
        check("sim_head", 96'(b_mreq), 96'(t2));
        cyc();
        b_mrsp.gnt = 1'b1;
        cyc();
        b_mrsp.gnt    = 1'b0;
        b_mrsp.rvalid = 1'b1;
        cyc();
        b_mrsp = '0;
        cyc();
        mid();
        check("sim_drain", 96'(u_b.inflight), 96'(0));
    endtask

    task automatic t_random();
        obi_req_t exp_dn[$];
        logic [31:0] exp_rsp[$];
        logic [31:0] pend_a[$];
        int pend_d[$];
        obi_req_t cur, tmp;
        logic [31:0] t32;
        int n = 0;
        cur = rnd_txn(0);
        for (int c = 0; c < 4000 && (n < 100 || exp_rsp.size() > 0); c++) begin
            cyc();
            a_req = (n < 100 && $urandom_range(0, 3) != 0) ? cur : '0;
            a_mrsp.gnt = ($urandom_range(0, 2) != 0);
            if (pend_a.size() > 0 && pend_d[0] <= c &&
                $urandom_range(0, 1) == 1) begin
                a_mrsp.rvalid = 1'b1;
                a_mrsp.rdata  = pend_a.pop_front();
                void'(pend_d.pop_front());
            end else begin
                a_mrsp.rvalid = 1'b0;
                a_mrsp.rdata  = 32'h0;
            end
            mid();
            if (a_req.req && a_rsp.gnt) begin
                exp_dn.push_back(cur);
                exp_rsp.push_back(cur.addr ^ K);
                n++;
                cur = rnd_txn(n);
            end
            if (a_mreq.req && a_mrsp.gnt) begin
                if (exp_dn.size() > 0) tmp = exp_dn.pop_front();
                else tmp = '0;
                check("rnd_req", 96'(a_mreq), 96'(tmp));
                pend_a.push_back(a_mreq.addr ^ K);
                pend_d.push_back(c + 1 + int'($urandom_range(0, 3)));
            end
            if (a_rsp.rvalid) begin
                if (exp_rsp.size() > 0) t32 = exp_rsp.pop_front();
                else t32 = 'x;
                check("rnd_rsp", 96'(a_rsp.rdata), 96'(t32));
            end
        end
        cyc();
        a_req  = '0;
        a_mrsp = '0;
        mid();
        check("rnd_issued", 96'(n), 96'(100));
        check("rnd_left", 96'(exp_rsp.size()), 96'(0));
        check("rnd_inflight", 96'(u_a.inflight), 96'(0));
    endtask

    task automatic t_reset_midflight();
        int seen = 0;
        b_mrsp = '0;
        cyc();
        b_req = mk(1'b1, 32'h6000_0000, 32'h1111_1111);
        cyc();
        b_req = mk(1'b1, 32'h6000_0004, 32'h2222_2222);
        cyc();
        b_req = '0;
        mid();
        check("rmf_full_gnt", 96'(b_rsp.gnt), 96'(0));
        check("rmf_cnt", 96'(u_b.cnt), 96'(2));
        #2 rst_n = 1'b0;
        #1;
        check("rmf_mreq", 96'(b_mreq), 96'(0));
        check("rmf_rsp", 96'(b_rsp), 96'({1'b1, 1'b0, 32'h0}));
        #1 rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            cyc();
            b_mrsp.gnt = 1'b1;
            mid();
            if (b_mreq.req) seen++;
        end
        b_mrsp = '0;
        check("rmf_discard", 96'(seen), 96'(0));
        check("rmf_inflight", 96'(u_b.inflight), 96'(0));
    endtask

    initial begin
        rst_n  = 1'b0;
        a_req  = '0;
        b_req  = '0;
        a_mrsp = '0;
        b_mrsp = '0;
        #12;
        check("rst_a_rsp", 96'(a_rsp), 96'({1'b1, 1'b0, 32'h0}));
        check("rst_a_mreq", 96'(a_mreq), 96'(0));
        check("rst_b_rsp", 96'(b_rsp), 96'({1'b1, 1'b0, 32'h0}));
        check("rst_b_mreq", 96'(b_mreq), 96'(0));
        #10 rst_n = 1'b1;
        t_single();
        t_backpressure();
        t_limit();
        t_simul();
        t_random();
        t_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
